cacheline_adapter: RTL and testbench



---
 rtl/cacheline_pkg.sv | 23 ++
 rtl/cacheline_adapter_chk.sv | 21 ++
 rtl/cacheline_adapter.sv | 172 +++++++++++++++++
 tb/tb_cacheline_adapter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_pkg.sv
// Shared types and constants for the cache-line to burst-memory adapter.
package cacheline_pkg;

   localparam int ADDR_W        = 32;
   localparam int LINE_W        = 256;
   localparam int BEAT_W        = 64;
   localparam int BEATS         = 4;
   localparam int LINE_OFFSET_W = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_WAIT  = 3'd2,
      WR_BURST = 3'd3,
      RESP     = 3'd4
   } adapter_state_t;

   // Drop the byte-within-line offset so bursts always start on a line boundary.
   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/cacheline_adapter_chk.sv
// Simulation-only protocol monitor for the adapter's two ports.
module cacheline_adapter_chk (
   input  logic clk,
   input  logic rst_n,
   input  logic dfp_read,
   input  logic dfp_write,
   input  logic bmem_rvalid,
   input  logic in_rd_wait
);

   // Flag requester and memory behaviour the adapter is not built to handle.
   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(dfp_read && dfp_write))
            else $warning("cacheline_adapter: dfp_read and dfp_write high together, write is serviced");
         assert (!(bmem_rvalid && !in_rd_wait))
            else $warning("cacheline_adapter: bmem_rvalid outside RD_WAIT is ignored");
      end
   end

endmodule

// File: rtl/cacheline_adapter.sv
// Turns one 256-bit cache line read/write into a 4-beat 64-bit memory burst,
// then pulses dfp_resp for one cycle.
module cacheline_adapter #(
   parameter int BEAT_W = cacheline_pkg::BEAT_W,
   parameter int BEATS  = cacheline_pkg::BEATS,
   parameter int LINE_W = cacheline_pkg::LINE_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       dfp_addr,
   input  logic              dfp_read,
   input  logic              dfp_write,
   input  logic [LINE_W-1:0] dfp_wdata,
   output logic [LINE_W-1:0] dfp_rdata,
   output logic              dfp_resp,
   output logic [31:0]       bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BEAT_W-1:0] bmem_wdata,
   input  logic              bmem_ready,
   input  logic [BEAT_W-1:0] bmem_rdata,
   input  logic              bmem_rvalid
);
   import cacheline_pkg::*;

   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   if (LINE_W != BEAT_W * BEATS) begin : g_width_check
      $error("cacheline_adapter: LINE_W must equal BEAT_W*BEATS");
   end

   adapter_state_t    state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  cnt_next_s;
   logic              last_beat_s;
   logic [BEAT_W-1:0] beat_r [BEATS];
   logic [LINE_W-1:0] assembled_s;
   logic              in_rd_wait_s;

   logic [LINE_W-1:0] dfp_rdata_r;
   logic              dfp_resp_r;
   logic [31:0]       bmem_addr_r;
   logic              bmem_read_r;
   logic              bmem_write_r;
   logic [BEAT_W-1:0] bmem_wdata_r;

   assign cnt_next_s   = cnt_r + 1'b1;
   assign last_beat_s  = (cnt_r == CNT_W'(BEATS - 1));
   assign in_rd_wait_s = (state_r == RD_WAIT);

   // Full read line as it will look once the beat arriving now is stored.
   always_comb begin
      assembled_s = '0;
      for (int i = 0; i < BEATS - 1; i++) begin
         assembled_s[i*BEAT_W +: BEAT_W] = beat_r[i];
      end
      assembled_s[(BEATS-1)*BEAT_W +: BEAT_W] = bmem_rdata;
   end

   // Line buffer: deliberately not reset, it only ever holds in-flight data.
   always_ff @(posedge clk) begin
      if ((state_r == IDLE) && dfp_write) begin
         for (int i = 0; i < BEATS; i++) begin
            beat_r[i] <= dfp_wdata[i*BEAT_W +: BEAT_W];
         end
      end else if ((state_r == RD_WAIT) && bmem_rvalid) begin
         beat_r[cnt_r] <= bmem_rdata;
      end
   end

   // Transaction FSM; every port output is a register updated alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= IDLE;
         cnt_r        <= '0;
         dfp_rdata_r  <= '0;
         dfp_resp_r   <= 1'b0;
         bmem_addr_r  <= 32'd0;
         bmem_read_r  <= 1'b0;
         bmem_write_r <= 1'b0;
         bmem_wdata_r <= '0;
      end else begin
         dfp_resp_r  <= 1'b0;
         dfp_rdata_r <= '0;
         case (state_r)
            IDLE: begin
               if (dfp_write) begin
                  state_r      <= WR_BURST;
                  cnt_r        <= '0;
                  bmem_addr_r  <= line_align(dfp_addr);
                  bmem_write_r <= 1'b1;
                  bmem_wdata_r <= dfp_wdata[BEAT_W-1:0];
               end else if (dfp_read) begin
                  state_r     <= RD_ISSUE;
                  bmem_addr_r <= line_align(dfp_addr);
                  bmem_read_r <= 1'b1;
               end else begin
                  state_r <= IDLE;
               end
            end
            RD_ISSUE: begin
               if (bmem_ready) begin
                  state_r     <= RD_WAIT;
                  cnt_r       <= '0;
                  bmem_read_r <= 1'b0;
                  bmem_addr_r <= 32'd0;
               end else begin
                  state_r <= RD_ISSUE;
               end
            end
            RD_WAIT: begin
               if (bmem_rvalid) begin
                  cnt_r <= cnt_next_s;
                  if (last_beat_s) begin
                     state_r     <= RESP;
                     dfp_resp_r  <= 1'b1;
                     dfp_rdata_r <= assembled_s;
                  end else begin
                     state_r <= RD_WAIT;
                  end
               end else begin
                  state_r <= RD_WAIT;
               end
            end
            WR_BURST: begin
               if (bmem_ready) begin
                  cnt_r <= cnt_next_s;
                  if (last_beat_s) begin
                     state_r      <= RESP;
                     dfp_resp_r   <= 1'b1;
                     bmem_write_r <= 1'b0;
                     bmem_addr_r  <= 32'd0;
                     bmem_wdata_r <= '0;
                  end else begin
                     bmem_wdata_r <= beat_r[cnt_next_s];
                  end
               end else begin
                  state_r <= WR_BURST;
               end
            end
            RESP: begin
               state_r <= IDLE;
            end
            default: begin
               state_r      <= IDLE;
               cnt_r        <= '0;
               bmem_addr_r  <= 32'd0;
               bmem_read_r  <= 1'b0;
               bmem_write_r <= 1'b0;
               bmem_wdata_r <= '0;
            end
         endcase
      end
   end

   assign dfp_rdata  = dfp_rdata_r;
   assign dfp_resp   = dfp_resp_r;
   assign bmem_addr  = bmem_addr_r;
   assign bmem_read  = bmem_read_r;
   assign bmem_write = bmem_write_r;
   assign bmem_wdata = bmem_wdata_r;

   cacheline_adapter_chk u_chk (
      .clk        (clk),
      .rst_n      (rst_n),
      .dfp_read   (dfp_read),
      .dfp_write  (dfp_write),
      .bmem_rvalid(bmem_rvalid),
      .in_rd_wait (in_rd_wait_s)
   );

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed plus randomized bench for cacheline_adapter with an inline burst-memory model.
module tb_cacheline_adapter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [31:0]  dfp_addr;
   logic         dfp_read;
   logic         dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;

   int errors = 0;
   int checks = 0;

   cacheline_adapter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .dfp_addr   (dfp_addr),
      .dfp_read   (dfp_read),
      .dfp_write  (dfp_write),
      .dfp_wdata  (dfp_wdata),
      .dfp_rdata  (dfp_rdata),
      .dfp_resp   (dfp_resp),
      .bmem_addr  (bmem_addr),
      .bmem_read  (bmem_read),
      .bmem_write (bmem_write),
      .bmem_wdata (bmem_wdata),
      .bmem_ready (bmem_ready),
      .bmem_rdata (bmem_rdata),
      .bmem_rvalid(bmem_rvalid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] rand_line();
      logic [255:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
      return l;
   endfunction

   function automatic bit bit_at(input logic [63:0] mask, input int c);
      return (c < 64) ? mask[c] : 1'b0;
   endfunction

   task automatic check_outputs_zero(input string tag);
      check({tag, "_resp"},  dfp_resp,   0);
      check({tag, "_rdata"}, dfp_rdata,  0);
      check({tag, "_addr"},  bmem_addr,  0);
      check({tag, "_read"},  bmem_read,  0);
      check({tag, "_write"}, bmem_write, 0);
      check({tag, "_wdata"}, bmem_wdata, 0);
   endtask

   // Line write; stall bit c pulls bmem_ready low in cycle c (request cycle is 0).
   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [63:0] stall, input bit also_read);
      int n_acc = 0;
      int resp_c = -1;
      int exp_resp;
      int n = 0;
      int c = 1;
      while (n < 4) begin
         if (!bit_at(stall, c)) n++;
         c++;
      end
      exp_resp = c;
      dfp_addr = addr; dfp_wdata = line; dfp_write = 1'b1; dfp_read = also_read;
      bmem_ready = 1'b0;
      for (int cyc = 1; cyc < 200 && resp_c < 0; cyc++) begin
         next_cycle();
         dfp_addr = $urandom; dfp_wdata = rand_line();
         bmem_ready = !bit_at(stall, cyc);
         check("wr_no_read", bmem_read, 0);
         if (dfp_resp) begin
            resp_c = cyc;
            check("wr_resp_cycle", cyc, exp_resp);
            check("wr_beat_count", n_acc, 4);
            check("wr_rdata_zero", dfp_rdata, 0);
            check("wr_write_low_in_resp", bmem_write, 0);
         end else if (bmem_write) begin
            check("wr_addr", bmem_addr, addr & 32'hFFFF_FFE0);
            if (n_acc < 4) check("wr_beat_data", bmem_wdata, line[n_acc*64 +: 64]);
            else check("wr_extra_beat", 1, 0);
            if (bmem_ready) n_acc++;
         end
      end
      if (resp_c < 0) check("wr_timeout", 0, 1);
      next_cycle();
      dfp_write = 1'b0; dfp_read = 1'b0; bmem_ready = 1'b0;
      check("wr_resp_one_cycle", dfp_resp, 0);
      next_cycle();
      check("wr_no_retrigger_write", bmem_write, 0);
      check("wr_no_retrigger_read", bmem_read, 0);
   endtask

   // Line read with memory model: beats start the cycle after the command is accepted
   // and skip cycles whose gap bit is set.
   task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                          input logic [63:0] stall, input logic [63:0] gap);
      int held = 0;
      int sent = 0;
      int resp_c = -1;
      int exp_resp = -1;
      int accept_c = -1;
      int exp_hold = 1;
      while (bit_at(stall, exp_hold)) exp_hold++;
      dfp_addr = addr; dfp_read = 1'b1; dfp_write = 1'b0;
      bmem_ready = 1'b0; bmem_rvalid = 1'b0;
      for (int cyc = 1; cyc < 200 && resp_c < 0; cyc++) begin
         next_cycle();
         dfp_addr = $urandom;
         check("rd_no_write", bmem_write, 0);
         if (dfp_resp) begin
            resp_c = cyc;
            bmem_rvalid = 1'b0;
            check("rd_resp_cycle", cyc, exp_resp);
            check("rd_line", dfp_rdata, line);
            check("rd_cmd_hold", held, exp_hold);
         end else begin
            bmem_ready = !bit_at(stall, cyc);
            if (bmem_read) begin
               held++;
               check("rd_addr", bmem_addr, addr & 32'hFFFF_FFE0);
               if (bmem_ready && accept_c < 0) accept_c = cyc;
            end
            if (accept_c > 0 && cyc > accept_c && sent < 4 && !bit_at(gap, cyc)) begin
               bmem_rvalid = 1'b1;
               bmem_rdata  = line[sent*64 +: 64];
               sent++;
               if (sent == 4) exp_resp = cyc + 1;
            end else begin
               bmem_rvalid = 1'b0;
               bmem_rdata  = {$urandom, $urandom};
            end
         end
      end
      if (resp_c < 0) check("rd_timeout", 0, 1);
      next_cycle();
      dfp_read = 1'b0; bmem_ready = 1'b0;
      check("rd_resp_one_cycle", dfp_resp, 0);
      check("rd_rdata_zero_after", dfp_rdata, 0);
      next_cycle();
      check("rd_no_retrigger", bmem_read, 0);
   endtask

   initial begin
      logic [255:0] l;
      rst_n = 1'b0;
      dfp_addr = 32'd0; dfp_read = 1'b0; dfp_write = 1'b0; dfp_wdata = '0;
      bmem_ready = 1'b0; bmem_rdata = 64'd0; bmem_rvalid = 1'b0;
      repeat (3) next_cycle();
      check_outputs_zero("reset");
      rst_n = 1'b1;
      next_cycle();
      check_outputs_zero("idle");

      // Read, memory always ready, consecutive beats.
      do_read(32'h1000_0024,
              {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
               64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
              64'd0, 64'd0);

      // Write, always ready; then ready low in cycles 2 and 3.
      do_write(32'h2000_0047, {64'hD, 64'hC, 64'hB, 64'hA}, 64'd0, 1'b0);
      do_write($urandom, rand_line(), 64'h0000_0000_0000_000C, 1'b0);

      // Read with command stalled 3 cycles and gaps between beats.
      do_read($urandom, rand_line(), 64'h0000_0000_0000_000E, 64'h0000_0000_0000_0340);

      // Asynchronous reset after two write beats have been accepted.
      dfp_addr = 32'h3000_0010; dfp_wdata = rand_line(); dfp_write = 1'b1; bmem_ready = 1'b1;
      repeat (3) next_cycle();
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("mid_reset");
      dfp_write = 1'b0; bmem_ready = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      do_read($urandom, rand_line(), 64'd0, 64'd0);

      // Stray rvalid in IDLE is ignored.
      for (int i = 0; i < 3; i++) begin
         bmem_rvalid = 1'b1; bmem_rdata = {$urandom, $urandom};
         next_cycle();
         check("stray_no_resp", dfp_resp, 0);
         check("stray_no_read", bmem_read, 0);
      end
      bmem_rvalid = 1'b0;
      next_cycle();
      check("stray_no_resp_after", dfp_resp, 0);
      do_read($urandom, rand_line(), 64'd0, 64'h0000_0000_0000_0020);

      // Read and write together: write wins.
      do_write($urandom, rand_line(), 64'd0, 1'b1);

      // Randomized mix with sparse stalls and gaps.
      for (int t = 0; t < 8; t++) begin
         logic [63:0] st;
         logic [63:0] gp;
         st = {32'd0, $urandom & $urandom & $urandom};
         gp = {32'd0, $urandom & $urandom};
         l  = rand_line();
         if ($urandom_range(0, 1) == 0) do_write($urandom, l, st, 1'b0);
         else do_read($urandom, l, st, gp);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
